// File: rtl/bottomhalf_bus_pkg.sv
// Shared types and constants for the bottom-half host bus initiator.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, bus drive bundle, ID register addresses,
// idle strobe levels and the OK-bit helper used by bus responders.
package bottomhalf_bus_pkg;

  localparam int BUS_W       = 8;
  localparam int PHASE_CNT_W = 8;
  localparam int ADDR_OK_BIT = 4;

  // Read-only identification registers of a bottom-half responder.
  localparam logic [BUS_W-1:0] ID_MAJOR_LO_ADDR = 8'hFD;
  localparam logic [BUS_W-1:0] ID_MAJOR_HI_ADDR = 8'hFE;
  localparam logic [BUS_W-1:0] ID_MINOR_ADDR    = 8'hFF;

  // Strobe levels while no access is in progress.
  localparam logic ALE_IDLE   = 1'b0;
  localparam logic WRITE_IDLE = 1'b1;
  localparam logic READ_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALE_HI   = 3'd1,
    ALE_HOLD = 3'd2,
    WR_LO    = 3'd3,
    WR_HOLD  = 3'd4,
    RD_LO    = 3'd5,
    RD_TURN  = 3'd6
  } bus_state_e;

  // Everything the master drives onto the pins, registered as one bundle.
  typedef struct packed {
    logic             ale;
    logic             write_n;
    logic             read_n;
    logic             oe;
    logic [BUS_W-1:0] dat;
  } bus_drive_t;

  localparam bus_drive_t DRV_IDLE = '{
    ale:     ALE_IDLE,
    write_n: WRITE_IDLE,
    read_n:  READ_IDLE,
    oe:      1'b0,
    dat:     '0
  };

  // A responder only answers addresses with the OK bit set.
  function automatic logic addr_is_ok(input logic [BUS_W-1:0] addr);
    return addr[ADDR_OK_BIT];
  endfunction

endpackage

// File: rtl/bottomhalf_bus_master_if.sv
// Request/response and pin bundle of the bottom-half bus initiator.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready handshake; responses are never stalled.
//
// master: the initiator (drives strobes, req_ready, responses).
// slave:  the request source plus the pin-level responder side.
interface bottomhalf_bus_master_if;
  import bottomhalf_bus_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [BUS_W-1:0] req_addr;
  logic [BUS_W-1:0] req_wdata;
  logic             rsp_valid;
  logic [BUS_W-1:0] rsp_rdata;
  logic [BUS_W-1:0] bus_data_out;
  logic             bus_data_oe;
  logic [BUS_W-1:0] bus_data_in;
  logic             bus_ale;
  logic             bus_write;
  logic             bus_read;
  logic             busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_data_in,
    output req_ready, rsp_valid, rsp_rdata,
    output bus_data_out, bus_data_oe, bus_ale, bus_write, bus_read, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_data_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  bus_data_out, bus_data_oe, bus_ale, bus_write, bus_read, busy
  );

endinterface

// File: rtl/bus_phase_timer.sv
// Phase length down-counter: start loads N-1, done is high in the Nth cycle.
// Latency: done asserts load_val cycles after the start edge.
// Backpressure: none; a new start always reloads, even mid-count.
//
// Ports: osc/rst clock and async active-high reset; start + load_val load
// the counter; done is high only in the final cycle of a running phase.
module bus_phase_timer
  import bottomhalf_bus_pkg::*;
(
  input  logic                   osc,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PHASE_CNT_W-1:0] load_val,
  output logic                   done
);

  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Gated by run_q so an idle counter sitting at zero never reads as done.
  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/bottomhalf_bus_master.sv
// Bottom-half bus initiator: one request -> ALE / WRITE / READ pin waveform.
// Latency: write 7, read 8 cycles to IDLE (4 / 5 when the ALE phase is skipped).
// Backpressure: req_ready only in IDLE; the response pulse cannot be stalled.
//
// Ports: osc clock, rst async active-high reset, bus (master modport) with
// request/response handshake, pin-level strobes/data and busy.
module bottomhalf_bus_master
  import bottomhalf_bus_pkg::*;
#(
  parameter int ALE_CYCLES     = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int STROBE_CYCLES  = 3,
  parameter int TURN_CYCLES    = 2,
  parameter int SKIP_SAME_ADDR = 1
) (
  input  logic                    osc,
  input  logic                    rst,
  bottomhalf_bus_master_if.master bus
);

  // Every phase length must fit the counter and be at least one cycle.
  if (ALE_CYCLES < 1 || ALE_CYCLES > 256 || HOLD_CYCLES < 1 || HOLD_CYCLES > 256 ||
      STROBE_CYCLES < 1 || STROBE_CYCLES > 256 || TURN_CYCLES < 1 || TURN_CYCLES > 256)
  begin : g_bad_phase_len
    $error("bottomhalf_bus_master: phase lengths must be in 1..256");
  end

  bus_state_e             state_q, state_d;
  logic [BUS_W-1:0]       addr_q, addr_d;
  logic [BUS_W-1:0]       wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [BUS_W-1:0]       cache_addr_q, cache_addr_d;
  logic                   cache_vld_q, cache_vld_d;
  bus_drive_t             drv_q, drv_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BUS_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                   cache_hit;
  logic                   timer_start;
  logic                   timer_done;
  logic [PHASE_CNT_W-1:0] timer_load;

  function automatic logic [PHASE_CNT_W-1:0] phase_load(input bus_state_e s);
    logic [PHASE_CNT_W-1:0] v;
    v = '0;
    case (s)
      ALE_HI:           v = PHASE_CNT_W'(ALE_CYCLES - 1);
      ALE_HOLD,
      WR_HOLD:          v = PHASE_CNT_W'(HOLD_CYCLES - 1);
      WR_LO,
      RD_LO:            v = PHASE_CNT_W'(STROBE_CYCLES - 1);
      RD_TURN:          v = PHASE_CNT_W'(TURN_CYCLES - 1);
      default:          v = '0;
    endcase
    return v;
  endfunction

  bus_phase_timer u_timer (
    .osc      (osc),
    .rst      (rst),
    .start    (timer_start),
    .load_val (timer_load),
    .done     (timer_done)
  );

  // Next state, request capture, cache and response.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    cache_addr_d = cache_addr_q;
    cache_vld_d  = cache_vld_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    cache_hit    = (SKIP_SAME_ADDR != 0) && cache_vld_q && (bus.req_addr == cache_addr_q);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          if (cache_hit) begin
            state_d = bus.req_write ? WR_LO : RD_LO;
          end else begin
            state_d = ALE_HI;
          end
        end
      end
      ALE_HI: begin
        if (timer_done) state_d = ALE_HOLD;
      end
      ALE_HOLD: begin
        // The responder has latched on the ALE falling edge by now.
        cache_addr_d = addr_q;
        cache_vld_d  = 1'b1;
        if (timer_done) state_d = write_q ? WR_LO : RD_LO;
      end
      WR_LO: begin
        if (timer_done) state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (timer_done) state_d = IDLE;
      end
      RD_LO: begin
        // Sample on the last READ-low edge, while the responder still drives.
        if (timer_done) begin
          state_d     = RD_TURN;
          rsp_rdata_d = bus.bus_data_in;
          rsp_valid_d = 1'b1;
        end
      end
      RD_TURN: begin
        if (timer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every state change into a timed phase reloads the counter.
    timer_start = (state_d != state_q) && (state_d != IDLE);
    timer_load  = phase_load(state_d);
  end

  // Pin drive is decoded from the next state so it registers in step with state_q.
  always_comb begin
    drv_d = DRV_IDLE;
    case (state_d)
      ALE_HI: begin
        drv_d.ale = 1'b1;
        drv_d.oe  = 1'b1;
        drv_d.dat = addr_d;
      end
      ALE_HOLD: begin
        drv_d.oe  = 1'b1;
        drv_d.dat = addr_d;
      end
      WR_LO: begin
        drv_d.write_n = 1'b0;
        drv_d.oe      = 1'b1;
        drv_d.dat     = wdata_d;
      end
      WR_HOLD: begin
        drv_d.oe  = 1'b1;
        drv_d.dat = wdata_d;
      end
      RD_LO: begin
        drv_d.read_n = 1'b0;
      end
      default: drv_d = DRV_IDLE;
    endcase
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      drv_q        <= DRV_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      cache_addr_q <= cache_addr_d;
      cache_vld_q  <= cache_vld_d;
      drv_q        <= drv_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.bus_ale      = drv_q.ale;
  assign bus.bus_write    = drv_q.write_n;
  assign bus.bus_read     = drv_q.read_n;
  assign bus.bus_data_oe  = drv_q.oe;
  assign bus.bus_data_out = drv_q.dat;

endmodule

// File: tb/tb_bottomhalf_bus_master.sv
// Directed bench for bottomhalf_bus_master with a behavioural bottom-half responder.
// Latency: n/a.
// Backpressure: requests are presented at negedge and held until accepted.
module tb_bottomhalf_bus_master;
  import bottomhalf_bus_pkg::*;

  logic osc;
  logic rst;
  bottomhalf_bus_master_if bif1 ();
  bottomhalf_bus_master_if bif2 ();

  bottomhalf_bus_master dut (.osc(osc), .rst(rst), .bus(bif1));
  bottomhalf_bus_master #(.SKIP_SAME_ADDR(0)) dut_noskip (.osc(osc), .rst(rst), .bus(bif2));

  initial osc = 1'b0;
  always #5 osc = ~osc;

  // Request drive, steered to one of the two masters by sel.
  logic       sel, r_valid, r_write;
  logic [7:0] r_addr, r_wdata;
  assign bif1.req_valid = r_valid & ~sel;
  assign bif2.req_valid = r_valid & sel;
  assign bif1.req_write = r_write;
  assign bif2.req_write = r_write;
  assign bif1.req_addr  = r_addr;
  assign bif2.req_addr  = r_addr;
  assign bif1.req_wdata = r_wdata;
  assign bif2.req_wdata = r_wdata;
  assign bif2.bus_data_in = 8'hFF;

  // Behavioural responder on bif1: latch address on ALE fall, write on WRITE rise.
  localparam logic [15:0] ID_MAJOR = 16'h0B07;
  localparam logic [7:0]  ID_MINOR = 8'h02;
  logic [7:0] mem [256];
  logic [7:0] resp_addr = 8'h00;
  logic [7:0] resp_val;

  always @(negedge bif1.bus_ale) resp_addr = bif1.bus_data_out;
  always @(posedge bif1.bus_write) if (addr_is_ok(resp_addr)) mem[resp_addr] = bif1.bus_data_out;

  always_comb begin
    resp_val = mem[resp_addr];
    if (resp_addr == ID_MAJOR_LO_ADDR) resp_val = ID_MAJOR[7:0];
    if (resp_addr == ID_MAJOR_HI_ADDR) resp_val = ID_MAJOR[15:8];
    if (resp_addr == ID_MINOR_ADDR)    resp_val = ID_MINOR;
  end
  // Undriven bus floats to the pull-up value.
  assign bif1.bus_data_in = (!bif1.bus_read && addr_is_ok(resp_addr)) ? resp_val : 8'hFF;

  // Observed signals of the selected master.
  logic       m_busy, m_ale, m_write, m_read, m_oe, m_rsp_valid;
  logic [7:0] m_dout, m_rdata;
  assign m_busy      = sel ? bif2.busy         : bif1.busy;
  assign m_ale       = sel ? bif2.bus_ale      : bif1.bus_ale;
  assign m_write     = sel ? bif2.bus_write    : bif1.bus_write;
  assign m_read      = sel ? bif2.bus_read     : bif1.bus_read;
  assign m_oe        = sel ? bif2.bus_data_oe  : bif1.bus_data_oe;
  assign m_rsp_valid = sel ? bif2.rsp_valid    : bif1.rsp_valid;
  assign m_dout      = sel ? bif2.bus_data_out : bif1.bus_data_out;
  assign m_rdata     = sel ? bif2.rsp_rdata    : bif1.rsp_rdata;

  int vectors = 0;
  int errors  = 0;

  int         o_busy, o_ale, o_wr, o_rd, o_rsp, o_viol;
  logic [7:0] o_ale_dat, o_wr_dat, o_rsp_dat;

  // Issue one request at the current negedge and record its waveform until IDLE.
  task automatic run_txn(input logic s, input logic w, input logic [7:0] a, input logic [7:0] d);
    bit done = 1'b0;
    sel = s; r_write = w; r_addr = a; r_wdata = d; r_valid = 1'b1;
    @(posedge osc);
    @(negedge osc);
    r_valid = 1'b0;
    o_busy = 0; o_ale = 0; o_wr = 0; o_rd = 0; o_rsp = 0; o_viol = 0;
    o_ale_dat = 8'h00; o_wr_dat = 8'h00; o_rsp_dat = 8'h00;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!m_busy) begin
        done = 1'b1;
      end else begin
        o_busy++;
        if (m_ale)    begin o_ale++; o_ale_dat = m_dout; end
        if (!m_write) begin o_wr++;  o_wr_dat  = m_dout; end
        if (!m_read)  o_rd++;
        if (m_rsp_valid) begin o_rsp++; o_rsp_dat = m_rdata; end
        if ((!m_read && m_oe) || (int'(m_ale) + int'(!m_write) + int'(!m_read) > 1)) o_viol++;
        @(negedge osc);
      end
    end
    vectors++;
    if (!done) begin errors++; $display("FAIL txn_timeout addr %h: still busy after 40 cycles, want IDLE", a); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge osc);
    rst = 1'b0;
    @(negedge osc);
    vectors++; if (bif1.bus_ale !== 1'b0)      begin errors++; $display("FAIL rst_ale: got %b want 0", bif1.bus_ale); end
    vectors++; if (bif1.bus_write !== 1'b1)    begin errors++; $display("FAIL rst_write: got %b want 1", bif1.bus_write); end
    vectors++; if (bif1.bus_read !== 1'b1)     begin errors++; $display("FAIL rst_read: got %b want 1", bif1.bus_read); end
    vectors++; if (bif1.bus_data_oe !== 1'b0)  begin errors++; $display("FAIL rst_oe: got %b want 0", bif1.bus_data_oe); end
    vectors++; if (bif1.bus_data_out !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", bif1.bus_data_out); end
    vectors++; if (bif1.req_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready: got %b want 1", bif1.req_ready); end
    vectors++; if (bif1.rsp_valid !== 1'b0)    begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bif1.rsp_valid); end
    vectors++; if (bif1.rsp_rdata !== 8'h00)   begin errors++; $display("FAIL rst_rdata: got %h want 00", bif1.rsp_rdata); end
    vectors++; if (bif1.busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", bif1.busy); end
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 8'h12, 8'hA5);
    vectors++; if (o_busy !== 7)        begin errors++; $display("FAIL wr_busy: got %0d want 7", o_busy); end
    vectors++; if (o_ale !== 2)         begin errors++; $display("FAIL wr_ale_cycles: got %0d want 2", o_ale); end
    vectors++; if (o_ale_dat !== 8'h12) begin errors++; $display("FAIL wr_ale_data: got %h want 12", o_ale_dat); end
    vectors++; if (o_wr !== 3)          begin errors++; $display("FAIL wr_strobe_cycles: got %0d want 3", o_wr); end
    vectors++; if (o_wr_dat !== 8'hA5)  begin errors++; $display("FAIL wr_data: got %h want A5", o_wr_dat); end
    vectors++; if (mem[8'h12] !== 8'hA5) begin errors++; $display("FAIL wr_responder_reg: got %h want A5", mem[8'h12]); end
  endtask

  task automatic test_id_read();
    logic [7:0] ids [3] = '{8'hFD, 8'hFE, 8'hFF};
    logic [7:0] exp [3] = '{8'h07, 8'h0B, 8'h02};
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b0, 1'b0, ids[k], 8'h00);
      vectors++; if (o_rsp_dat !== exp[k]) begin errors++; $display("FAIL id_rdata %h: got %h want %h", ids[k], o_rsp_dat, exp[k]); end
      vectors++; if (o_rsp !== 1)  begin errors++; $display("FAIL id_rsp_pulses %h: got %0d want 1", ids[k], o_rsp); end
      vectors++; if (o_busy !== 8) begin errors++; $display("FAIL id_busy %h: got %0d want 8", ids[k], o_busy); end
      vectors++; if (o_rd !== 3)   begin errors++; $display("FAIL id_read_cycles %h: got %0d want 3", ids[k], o_rd); end
      vectors++; if (o_viol !== 0) begin errors++; $display("FAIL id_oe_or_strobe_overlap %h: got %0d want 0", ids[k], o_viol); end
    end
  endtask

  task automatic test_skip_same_addr();
    run_txn(1'b0, 1'b1, 8'h12, 8'h5A);
    vectors++; if (o_ale !== 2)  begin errors++; $display("FAIL skip_first_ale: got %0d want 2", o_ale); end
    run_txn(1'b0, 1'b1, 8'h12, 8'h3C);
    vectors++; if (o_ale !== 0)  begin errors++; $display("FAIL skip_second_ale: got %0d want 0", o_ale); end
    vectors++; if (o_busy !== 4) begin errors++; $display("FAIL skip_second_busy: got %0d want 4", o_busy); end
    vectors++; if (mem[8'h12] !== 8'h3C) begin errors++; $display("FAIL skip_responder_reg: got %h want 3C", mem[8'h12]); end
    run_txn(1'b1, 1'b1, 8'h12, 8'h5A);
    run_txn(1'b1, 1'b1, 8'h12, 8'h3C);
    vectors++; if (o_ale !== 2)  begin errors++; $display("FAIL noskip_second_ale: got %0d want 2", o_ale); end
    vectors++; if (o_busy !== 7) begin errors++; $display("FAIL noskip_second_busy: got %0d want 7", o_busy); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit found = 1'b0;
    int pulses = 0;
    sel = 1'b0; r_write = 1'b0; r_addr = 8'h12; r_valid = 1'b1;
    @(posedge osc);
    @(negedge osc);
    r_valid = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (!bif1.bus_read) found = 1'b1;
      else @(negedge osc);
    end
    vectors++; if (!found) begin errors++; $display("FAIL rstmid_read_low: READ never went low, want low"); end
    rst = 1'b1;
    #1;
    vectors++; if (bif1.bus_read !== 1'b1)    begin errors++; $display("FAIL rstmid_read: got %b want 1", bif1.bus_read); end
    vectors++; if (bif1.bus_data_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe: got %b want 0", bif1.bus_data_oe); end
    vectors++; if (bif1.bus_ale !== 1'b0)     begin errors++; $display("FAIL rstmid_ale: got %b want 0", bif1.bus_ale); end
    vectors++; if (bif1.bus_write !== 1'b1)   begin errors++; $display("FAIL rstmid_write: got %b want 1", bif1.bus_write); end
    @(negedge osc);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge osc);
      if (bif1.rsp_valid) pulses++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_rsp_valid: got %0d pulses want 0", pulses); end
    run_txn(1'b0, 1'b0, 8'h12, 8'h00);
    vectors++; if (o_ale !== 2)         begin errors++; $display("FAIL rstmid_reissue_ale: got %0d want 2", o_ale); end
    vectors++; if (o_rsp_dat !== 8'h3C) begin errors++; $display("FAIL rstmid_reissue_rdata: got %h want 3C", o_rsp_dat); end
  endtask

  task automatic test_back_to_back();
    logic       qw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] qa [4] = '{8'h30, 8'h30, 8'h31, 8'h31};
    logic [7:0] qd [4] = '{8'h11, 8'h00, 8'h00, 8'hC3};
    logic [7:0] rsp [2] = '{8'h00, 8'h00};
    int acc = 0, busy_n = 0, idle_n = 0, nrsp = 0;
    bit rdy, done = 1'b0;
    sel = 1'b0; r_write = qw[0]; r_addr = qa[0]; r_wdata = qd[0]; r_valid = 1'b1;
    for (int c = 0; c < 80 && !done; c++) begin
      if (bif1.busy) busy_n++;
      else if (acc == 4) done = 1'b1;
      else if (acc > 0) idle_n++;
      if (bif1.rsp_valid) begin
        if (nrsp < 2) rsp[nrsp] = bif1.rsp_rdata;
        nrsp++;
      end
      rdy = bif1.req_ready && r_valid;
      if (!done) begin
        @(negedge osc);
        if (rdy) begin
          acc++;
          if (acc < 4) begin r_write = qw[acc]; r_addr = qa[acc]; r_wdata = qd[acc]; end
          else r_valid = 1'b0;
        end
      end
    end
    vectors++; if (!done)        begin errors++; $display("FAIL b2b_timeout: accepted %0d want 4 and idle", acc); end
    vectors++; if (busy_n !== 24) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 24", busy_n); end
    vectors++; if (idle_n !== 3) begin errors++; $display("FAIL b2b_idle_gaps: got %0d want 3", idle_n); end
    vectors++; if (nrsp !== 2)   begin errors++; $display("FAIL b2b_rsp_count: got %0d want 2", nrsp); end
    vectors++; if (rsp[0] !== 8'h11) begin errors++; $display("FAIL b2b_rsp0: got %h want 11", rsp[0]); end
    vectors++; if (rsp[1] !== 8'h6B) begin errors++; $display("FAIL b2b_rsp1: got %h want 6B", rsp[1]); end
    vectors++; if (mem[8'h31] !== 8'hC3) begin errors++; $display("FAIL b2b_mem31: got %h want C3", mem[8'h31]); end
  endtask

  task automatic test_unmapped_read();
    run_txn(1'b0, 1'b0, 8'h02, 8'h00);
    vectors++; if (o_rsp_dat !== 8'hFF) begin errors++; $display("FAIL unmapped_rdata: got %h want FF", o_rsp_dat); end
    vectors++; if (o_busy !== 8)        begin errors++; $display("FAIL unmapped_busy: got %0d want 8", o_busy); end
    vectors++; if (o_ale_dat !== 8'h02) begin errors++; $display("FAIL unmapped_ale_data: got %h want 02", o_ale_dat); end
    vectors++; if (o_rsp !== 1)         begin errors++; $display("FAIL unmapped_rsp_pulses: got %0d want 1", o_rsp); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst = 1'b1; sel = 1'b0; r_valid = 1'b0; r_write = 1'b0; r_addr = 8'h00; r_wdata = 8'h00;
    test_reset();
    test_write();
    test_id_read();
    test_skip_same_addr();
    test_reset_mid_read();
    test_back_to_back();
    test_unmapped_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, want completion");
    $fatal(1);
  end

endmodule
